// File: rtl/sha256_pkg.sv
// SHA-256 constants, round/schedule helper functions and shared types for the
// streaming hash core.
package sha256_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_SCHED, S_ROUND, S_FINAL, S_DPASS, S_OUT
   } state_e;

   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } hstate_t;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, y, z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, y, z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Word-wise mod-2^32 sum of two eight-word hash states.
   function automatic logic [255:0] add_words(input logic [255:0] x, y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; chained UNROLL deep by the core.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] st_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] st_out
);

   hstate_t s, r;
   logic [31:0] t1, t2;

   assign s = st_in;

   always_comb begin
      t1 = s.h + big_s1(s.e) + ch(s.e, s.f, s.g) + k + w;
      t2 = big_s0(s.a) + maj(s.a, s.b, s.c);
      r = '{a: t1 + t2, b: s.a, c: s.b, d: s.c, e: s.d + t1, f: s.e, g: s.f, h: s.g};
   end

   assign st_out = r;

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 / SHA-256d engine: block chaining, optional midstate load and
// an internal second pass, UNROLL rounds per clock.
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int UNROLL    = 4,
   parameter bit DOUBLE_EN = 1'b1
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_use_mid,
   input  logic [255:0] in_midstate,
   input  logic         in_last,
   input  logic         in_double,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_hash,
   output logic         busy
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
   end

   localparam int NRND = 64 / UNROLL;

   state_e              state;
   logic                rdy;
   logic [15:0][31:0]   w;
   logic [255:0]        wk;
   logic [255:0]        hc;
   logic [255:0]        hsum;
   logic [255:0]        rnd_out;
   logic                last_r, dbl_r;
   logic [6:0]          rnd;
   logic [5:0]          kb;
   logic                ov;
   logic [255:0]        oh;

   // Window holds W[t..t+15]; produce UNROLL new words and slide by UNROLL.
   function automatic logic [15:0][31:0] next_window(input logic [15:0][31:0] cur);
      logic [31:0]       ext [16+UNROLL];
      logic [15:0][31:0] r;
      for (int i = 0; i < 16; i++) ext[i] = cur[i];
      for (int j = 0; j < UNROLL; j++)
         ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
      for (int i = 0; i < 16; i++) r[i] = ext[i+UNROLL];
      return r;
   endfunction

   assign kb = 6'(rnd * UNROLL);

   for (genvar gj = 0; gj < UNROLL; gj++) begin : g_rnd
      localparam logic [5:0] OFS = 6'(gj);
      logic [255:0] si, so;
      if (gj == 0) begin : g_head
         assign si = wk;
      end else begin : g_link
         assign si = g_rnd[gj-1].so;
      end
      sha256_round u_round (
         .st_in  (si),
         .k      (K[kb + OFS]),
         .w      (w[gj]),
         .st_out (so)
      );
   end

   assign rnd_out = g_rnd[UNROLL-1].so;
   assign hsum    = add_words(hc, wk);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         rdy    <= 1'b0;
         w      <= '0;
         wk     <= '0;
         hc     <= IV;
         last_r <= 1'b0;
         dbl_r  <= 1'b0;
         rnd    <= '0;
         ov     <= 1'b0;
         oh     <= '0;
      end else if (clear) begin
         state  <= S_IDLE;
         rdy    <= 1'b1;
         hc     <= IV;
         last_r <= 1'b0;
         dbl_r  <= 1'b0;
         rnd    <= '0;
         ov     <= 1'b0;
         oh     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && rdy) begin
                  for (int i = 0; i < 16; i++) w[i] <= in_block[511-32*i -: 32];
                  if (in_first) hc <= in_use_mid ? in_midstate : IV;
                  last_r <= in_last;
                  dbl_r  <= in_last & in_double & DOUBLE_EN;
                  rdy    <= 1'b0;
                  state  <= S_SCHED;
               end else begin
                  rdy <= 1'b1;
               end
            end
            S_SCHED: begin
               wk    <= hc;
               rnd   <= '0;
               state <= S_ROUND;
            end
            S_ROUND: begin
               wk <= rnd_out;
               w  <= next_window(w);
               if (rnd == 7'(NRND - 1)) state <= S_FINAL;
               else                     rnd   <= rnd + 7'd1;
            end
            S_FINAL: begin
               if (!last_r) begin
                  hc    <= hsum;
                  rdy   <= 1'b1;
                  state <= S_IDLE;
               end else if (dbl_r) begin
                  hc    <= hsum;
                  state <= S_DPASS;
               end else begin
                  oh    <= hsum;
                  ov    <= 1'b1;
                  hc    <= IV;
                  state <= S_OUT;
               end
            end
            S_DPASS: begin
               // Second pass hashes the 256-bit digest as one padded block.
               for (int i = 0; i < 8; i++) w[i] <= hc[255-32*i -: 32];
               w[8] <= 32'h80000000;
               for (int i = 9; i < 15; i++) w[i] <= 32'h0;
               w[15] <= 32'h00000100;
               hc    <= IV;
               dbl_r <= 1'b0;
               state <= S_SCHED;
            end
            S_OUT: begin
               if (out_ready) begin
                  ov    <= 1'b0;
                  oh    <= '0;
                  rdy   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               rdy   <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = rdy;
   assign out_valid = ov;
   assign out_hash  = oh;
   assign busy      = (state != S_IDLE) || ov;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: four cores (UNROLL 1,2,4,8) share one stimulus stream and are
// checked against known SHA-256 / SHA-256d digests.
module tb_sha256_stream_core;

   localparam int N = 4;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
   localparam logic [511:0] GEN1 = {32'h01000000, {8{32'h0}}, 32'h3ba3edfd, 32'h7a7b12b2,
                                    32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
   localparam logic [511:0] GEN2 = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c,
                                    32'h80000000, {10{32'h0}}, 32'h00000280};
   localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] H_EMPD  = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
   localparam logic [255:0] H_GEN   = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
   localparam logic [255:0] JUNK    = 256'hdeadbeef_01234567_89abcdef_cafef00d_0badf00d_13579bdf_2468ace0_55aa55aa;

   logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic in_valid = 1'b0, in_first = 1'b0, in_use_mid = 1'b0, in_last = 1'b0, in_double = 1'b0;
   logic out_ready = 1'b0;
   logic [511:0] in_block = '0;
   logic [255:0] in_midstate = '0;
   logic [N-1:0] in_ready, out_valid, busy;
   logic [N-1:0][255:0] out_hash;

   int errs = 0, checks = 0;
   int lat [N];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      sha256_stream_core #(.UNROLL(1 << gi), .DOUBLE_EN(1'b1)) u_dut (
         .clk(clk), .rst_n(rst_n), .clear(clear),
         .in_valid(in_valid), .in_ready(in_ready[gi]), .in_block(in_block),
         .in_first(in_first), .in_use_mid(in_use_mid), .in_midstate(in_midstate),
         .in_last(in_last), .in_double(in_double),
         .out_valid(out_valid[gi]), .out_ready(out_ready), .out_hash(out_hash[gi]),
         .busy(busy[gi])
      );
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Offer one block once every core is ready; returns on the negedge after the transfer.
   task automatic send(input logic [511:0] b, input logic f, input logic m,
                       input logic [255:0] mid, input logic l, input logic d);
      int n = 0;
      @(negedge clk);
      while (in_ready != '1 && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (in_ready != '1) begin
         errs++;
         $display("FAIL send_ready in_ready=%b expected=%b", in_ready, {N{1'b1}});
      end
      in_block = b; in_first = f; in_use_mid = m; in_midstate = mid; in_last = l; in_double = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_use_mid = 1'b0; in_last = 1'b0; in_double = 1'b0;
   endtask

   // Count cycles from the transfer edge until each core raises out_valid.
   task automatic wait_out();
      int n = 0;
      for (int i = 0; i < N; i++) lat[i] = -1;
      while (out_valid != '1 && n < 400) begin
         @(negedge clk); n++;
         for (int i = 0; i < N; i++) if (out_valid[i] && lat[i] < 0) lat[i] = n;
      end
      checks++;
      if (out_valid != '1) begin
         errs++;
         $display("FAIL out_timeout out_valid=%b expected=%b", out_valid, {N{1'b1}});
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== '0 || out_valid !== '0 || busy !== '0) begin
         errs++;
         $display("FAIL reset_ctl in_ready=%b out_valid=%b busy=%b expected all 0", in_ready, out_valid, busy);
      end
      checks++;
      if (out_hash !== '0) begin
         errs++;
         $display("FAIL reset_hash out_hash=%h expected 0", out_hash);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== '1) begin
         errs++;
         $display("FAIL reset_ready in_ready=%b expected=%b", in_ready, {N{1'b1}});
      end
   endtask

   task automatic test_abc();
      send(BLK_ABC, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_ABC) begin
            errs++;
            $display("FAIL abc_hash u%0d got=%h expected=%h", 1 << i, out_hash[i], H_ABC);
         end
         checks++;
         if (lat[i] != 2 + 64 / (1 << i)) begin
            errs++;
            $display("FAIL abc_latency u%0d got=%0d expected=%0d", 1 << i, lat[i], 2 + 64 / (1 << i));
         end
      end
      pop();
      checks++;
      if (out_valid !== '0 || busy !== '0 || out_hash !== '0) begin
         errs++;
         $display("FAIL abc_pop out_valid=%b busy=%b hash_nonzero=%0d expected 0", out_valid, busy, out_hash != '0);
      end
   endtask

   task automatic test_empty_double();
      send(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_EMPD) begin
            errs++;
            $display("FAIL empty_double u%0d got=%h expected=%h", 1 << i, out_hash[i], H_EMPD);
         end
      end
      pop();
   endtask

   task automatic test_genesis();
      // in_double on a non-last block and in_use_mid on a non-first block must be ignored.
      send(GEN1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      send(GEN2, 1'b0, 1'b1, JUNK, 1'b1, 1'b1);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_GEN) begin
            errs++;
            $display("FAIL genesis u%0d got=%h expected=%h", 1 << i, out_hash[i], H_GEN);
         end
      end
      pop();
   endtask

   task automatic test_midstate();
      logic [255:0] mid;
      send(GEN1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      wait_out();
      mid = out_hash[0];
      pop();
      send(GEN2, 1'b1, 1'b1, mid, 1'b1, 1'b1);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_GEN) begin
            errs++;
            $display("FAIL midstate u%0d got=%h expected=%h", 1 << i, out_hash[i], H_GEN);
         end
      end
      pop();
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      send(BLK_ABC, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      wait_out();
      in_block = BLK_EMPTY; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (out_hash[i] !== H_ABC || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errs++;
         $display("FAIL backpressure_hold bad_samples=%0d expected=0", bad);
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      pop();
      checks++;
      if (busy !== '0 || in_ready !== '1) begin
         errs++;
         $display("FAIL backpressure_release busy=%b in_ready=%b expected busy=0 ready=1", busy, in_ready);
      end
      send(BLK_EMPTY, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_EMPTY) begin
            errs++;
            $display("FAIL after_backpressure u%0d got=%h expected=%h", 1 << i, out_hash[i], H_EMPTY);
         end
      end
      pop();
   endtask

   task automatic test_clear();
      int rose = 0;
      send(GEN1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== '1) begin
         errs++;
         $display("FAIL clear_pre busy=%b expected=%b", busy, {N{1'b1}});
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++;
      if (busy !== '0 || in_ready !== '1) begin
         errs++;
         $display("FAIL clear_idle busy=%b in_ready=%b expected busy=0 ready=1", busy, in_ready);
      end
      // Async reset in the middle of a single-block message must also drop it silently.
      send(BLK_ABC, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (out_valid != '0) rose++;
      end
      checks++;
      if (rose != 0) begin
         errs++;
         $display("FAIL abort_no_output out_valid_samples=%0d expected=0", rose);
      end
      // Chain must be back at IV: in_first=0 and in_use_mid are don't-cares here.
      send(BLK_ABC, 1'b0, 1'b1, JUNK, 1'b1, 1'b0);
      wait_out();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_hash[i] !== H_ABC) begin
            errs++;
            $display("FAIL after_clear u%0d got=%h expected=%h", 1 << i, out_hash[i], H_ABC);
         end
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty_double();
      test_genesis();
      test_midstate();
      test_back_to_back();
      test_clear();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
